// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: DEPTH-byte FIFO feeding a UART 8N1 line driver (8E1 when UART_TX_PARITY_EN is defined).
// Latency: byte pushed at edge k is popped at edge k+1; its start bit appears on o_tx after edge k+2.
// Backpressure: o_ready is registered low while full; a push then is dropped and latches o_overflow.
module uart_tx_fifo #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               i_data,
  input  logic                     i_valid,
  output logic                     o_ready,
  output logic                     o_tx,
  output logic                     o_idle,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_overflow
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd4;
`endif

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          ready_q;
  logic          ovf_q;

  logic [2:0]    state_q;
  logic [2:0]    state_d;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          tx_d;
`ifdef UART_TX_PARITY_EN
  logic          parity_q;
`endif

  logic push;
  logic pop;
  logic bit_done;

  assign push     = i_valid & ready_q;
  assign pop      = (state_q == S_IDLE) && (count_q != '0);
  assign bit_done = (baud_cnt == BAUD_LAST);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset: emptiness is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ready_q <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d != FULL_CNT);
      if (i_valid && !ready_q) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_done && (bit_idx == 3'd7)) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_done) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level for the current state; registered below so o_tx trails the FSM by one cycle.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = parity_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;

      if (state_q == S_IDLE || bit_done) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end

      if (pop) begin
        shift_q  <= mem[rd_ptr];
        bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
        parity_q <= ^mem[rd_ptr];
`endif
      end else if (state_q == S_START && bit_done) begin
        bit_idx <= '0;
      end else if (state_q == S_DATA && bit_done) begin
        shift_q <= {1'b0, shift_q[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
    end
  end

  assign o_tx       = tx_q;
  assign o_ready    = ready_q;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_idle     = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: line decoder feeds a byte scoreboard; tasks check timing and flags.
module tb_uart_tx_fifo;

  localparam int CLK_FREQ = 1000;
  localparam int BAUD     = 100;
  localparam int DEPTH    = 4;
  localparam int CPB      = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;
  localparam int STOP_CYC  = (FRAME_BITS - 1) * CPB + 5;

  logic       clk;
  logic       rst_n;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic       o_tx;
  logic       o_idle;
  logic [2:0] o_count;
  logic       o_overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] exp_q[$];
  int         start_q[$];

  bit         mon_busy = 1'b0;
  int         mon_cyc = 0;
  logic [7:0] mon_byte = '0;
  logic [7:0] mon_exp = '0;

  uart_tx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .i_data(i_data), .i_valid(i_valid),
    .o_ready(o_ready), .o_tx(o_tx), .o_idle(o_idle), .o_count(o_count),
    .o_overflow(o_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Line decoder: samples mid-bit and checks each received byte against the scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (o_tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_cyc  = 0;
        start_q.push_back(cyc);
      end
    end else begin
      mon_cyc++;
      if (mon_cyc == 5) begin
        checks++;
        if (o_tx !== 1'b0) begin
          errors++;
          $display("FAIL start_bit got=%b exp=0", o_tx);
        end
      end else if (mon_cyc >= 15 && mon_cyc <= 85 && (mon_cyc - 15) % 10 == 0) begin
        mon_byte[(mon_cyc - 15) / 10] = o_tx;
`ifdef UART_TX_PARITY_EN
      end else if (mon_cyc == 95) begin
        checks++;
        if (o_tx !== ^mon_byte) begin
          errors++;
          $display("FAIL parity_bit byte=%h got=%b exp=%b", mon_byte, o_tx, ^mon_byte);
        end
`endif
      end else if (mon_cyc == STOP_CYC) begin
        checks++;
        if (o_tx !== 1'b1) begin
          errors++;
          $display("FAIL stop_bit got=%b exp=1", o_tx);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected got=%h exp=none", mon_byte);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_byte !== mon_exp) begin
            errors++;
            $display("FAIL sb_byte got=%h exp=%h", mon_byte, mon_exp);
          end
        end
        mon_busy = 1'b0;
      end
    end
  end

  function automatic logic exp_tx(input logic [7:0] b, input int j);
    if (j < 2) return 1'b1;
    if (j < 12) return 1'b0;
    if (j < 92) return b[(j - 12) / 10];
`ifdef UART_TX_PARITY_EN
    if (j < 102) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic wait_drain(input int budget, input string name);
    bit done;
    done = 1'b0;
    for (int n = 0; n < budget && !done; n++) begin
      @(negedge clk);
      if (o_idle && exp_q.size() == 0 && !mon_busy) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain got=timeout pending=%0d exp=drained", name, exp_q.size());
    end
  endtask

  // Pushes one byte into an idle block and checks o_tx cycle by cycle plus o_idle edges.
  task automatic check_frame(input logic [7:0] b);
    @(negedge clk);
    i_data  = b;
    i_valid = 1'b1;
    exp_q.push_back(b);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    for (int j = 0; j <= FRAME_CYC + 1; j++) begin
      @(negedge clk);
      checks++;
      if (o_tx !== exp_tx(b, j)) begin
        errors++;
        $display("FAIL frame_tx byte=%h j=%0d got=%b exp=%b", b, j, o_tx, exp_tx(b, j));
      end
      if (j == 0 || j == FRAME_CYC) begin
        checks++;
        if (o_idle !== 1'b0) begin
          errors++;
          $display("FAIL frame_idle_low byte=%h j=%0d got=%b exp=0", b, j, o_idle);
        end
      end
      if (j == FRAME_CYC + 1) begin
        checks++;
        if (o_idle !== 1'b1) begin
          errors++;
          $display("FAIL frame_idle_high byte=%h j=%0d got=%b exp=1", b, j, o_idle);
        end
      end
    end
    wait_drain(50, "frame");
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    #23;
    checks += 5;
    if (o_tx !== 1'b1)       begin errors++; $display("FAIL rst_tx got=%b exp=1", o_tx); end
    if (o_ready !== 1'b1)    begin errors++; $display("FAIL rst_ready got=%b exp=1", o_ready); end
    if (o_idle !== 1'b1)     begin errors++; $display("FAIL rst_idle got=%b exp=1", o_idle); end
    if (o_count !== 3'd0)    begin errors++; $display("FAIL rst_count got=%0d exp=0", o_count); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", o_overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    check_frame(8'h77);
  endtask

  task automatic test_burst;
    logic [7:0] bytes [4];
    bytes[0] = 8'h0d; bytes[1] = 8'h20; bytes[2] = 8'h61; bytes[3] = 8'h64;
    start_q.delete();
    @(negedge clk);
    i_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_data = bytes[i];
      exp_q.push_back(bytes[i]);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    @(negedge clk);
    checks += 2;
    if (o_count !== 3'd3) begin errors++; $display("FAIL burst_count got=%0d exp=3", o_count); end
    if (o_ready !== 1'b1) begin errors++; $display("FAIL burst_ready got=%b exp=1", o_ready); end
    wait_drain(4 * (FRAME_CYC + 1) + 50, "burst");
    checks++;
    if (start_q.size() != 4) begin
      errors++;
      $display("FAIL burst_frames got=%0d exp=4", start_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (start_q[i+1] - start_q[i] != FRAME_CYC + 1) begin
          errors++;
          $display("FAIL burst_period got=%0d exp=%0d", start_q[i+1] - start_q[i], FRAME_CYC + 1);
        end
      end
    end
  endtask

  task automatic test_simul_push_pop;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 8'h3c;
    exp_q.push_back(8'h3c);
    @(posedge clk);
    #1;
    checks++;
    if (o_count !== 3'd1) begin errors++; $display("FAIL simul_count0 got=%0d exp=1", o_count); end
    i_data = 8'hc3;
    exp_q.push_back(8'hc3);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (o_count !== 3'd1) begin errors++; $display("FAIL simul_count1 got=%0d exp=1", o_count); end
    wait_drain(2 * (FRAME_CYC + 1) + 50, "simul");
  endtask

  task automatic test_overflow;
    logic [7:0] bytes [6];
    bytes[0] = 8'h10; bytes[1] = 8'h21; bytes[2] = 8'h32;
    bytes[3] = 8'h43; bytes[4] = 8'h54; bytes[5] = 8'hee;
    @(negedge clk);
    i_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_data = bytes[i];
      checks++;
      if (o_ready !== (i < 5)) begin
        errors++;
        $display("FAIL ovf_ready_seq i=%0d got=%b exp=%b", i, o_ready, (i < 5));
      end
      if (i < 5) exp_q.push_back(bytes[i]);
      @(posedge clk);
      #1;
    end
    i_valid = 1'b0;
    @(negedge clk);
    checks += 3;
    if (o_count !== 3'd4)    begin errors++; $display("FAIL ovf_count got=%0d exp=4", o_count); end
    if (o_ready !== 1'b0)    begin errors++; $display("FAIL ovf_ready got=%b exp=0", o_ready); end
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", o_overflow); end
    wait_drain(5 * (FRAME_CYC + 1) + 50, "ovf");
    checks++;
    if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", o_overflow); end
  endtask

  task automatic test_reset_midframe;
    @(negedge clk);
    i_valid = 1'b1;
    i_data  = 8'hA5;
    exp_q.push_back(8'hA5);
    @(posedge clk);
    #1;
    i_data = 8'h11;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (46) @(negedge clk);
    checks++;
    if (o_tx !== 1'b0) begin errors++; $display("FAIL mid_bit3 got=%b exp=0", o_tx); end
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checks += 5;
    if (o_tx !== 1'b1)       begin errors++; $display("FAIL mid_rst_tx got=%b exp=1", o_tx); end
    if (o_count !== 3'd0)    begin errors++; $display("FAIL mid_rst_count got=%0d exp=0", o_count); end
    if (o_overflow !== 1'b0) begin errors++; $display("FAIL mid_rst_ovf got=%b exp=0", o_overflow); end
    if (o_ready !== 1'b1)    begin errors++; $display("FAIL mid_rst_ready got=%b exp=1", o_ready); end
    if (o_idle !== 1'b1)     begin errors++; $display("FAIL mid_rst_idle got=%b exp=1", o_idle); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_frame(8'h73);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    check_frame(8'h61);
    check_frame(8'h00);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_simul_push_pop();
    test_overflow();
    test_reset_midframe();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    repeat (20) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
